race_fsm: RTL

RACE_FSM -- requirements
Module: race_fsm

---
 rtl/race_pkg.sv | 22 ++
 rtl/frame_down_counter.sv | 34 +++
 rtl/race_fsm.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/race_pkg.sv
// Shared types and widths for the race controller and its counters.
package race_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_RACE      = 3'd2,
    ST_PAUSE     = 3'd3,
    ST_FINISH    = 3'd4
  } race_state_e;

  localparam int unsigned LAP_W = 4;
  localparam int unsigned RF_W  = 16;

  localparam logic [RF_W-1:0] RF_MAX = '1;

  // Frame timer stops at all-ones instead of wrapping to zero.
  function automatic logic [RF_W-1:0] rf_sat_inc(input logic [RF_W-1:0] v);
    return (v == RF_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/frame_down_counter.sv
// Loadable down-counter that steps once per enabled frame and parks at zero.
module frame_down_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/race_fsm.sv
// Race game sequencer: countdown, timed race with per-car lap counting,
// pause/resume and a timed results screen.
module race_fsm
  import race_pkg::*;
#(
  parameter int N_PLAYERS  = 2,
  parameter int LAPS       = 3,
  parameter int CD_FRAMES  = 180,
  parameter int FIN_FRAMES = 300
) (
  input  logic                             pclk,
  input  logic                             rst,
  input  logic                             frame_tick,
  input  logic                             start,
  input  logic [N_PLAYERS-1:0]             lap_pulse,
  output logic [2:0]                       state,
  output logic [$clog2(CD_FRAMES+1)-1:0]   cd_left,
  output logic [N_PLAYERS*LAP_W-1:0]       laps,
  output logic [RF_W-1:0]                  race_frames,
  output logic [1:0]                       winner,
  output logic                             winner_valid
);

  localparam int unsigned CD_W   = $clog2(CD_FRAMES + 1);
  localparam int unsigned HOLD_W = $clog2(FIN_FRAMES + 1);

  localparam logic [LAP_W-1:0]  LAP_MAX = LAP_W'(LAPS);
  localparam logic [CD_W-1:0]   CD_INIT = CD_W'(CD_FRAMES);
  localparam logic [HOLD_W-1:0] FIN_INIT = HOLD_W'(FIN_FRAMES);

  race_state_e      state_q, state_d;
  logic [RF_W-1:0]  rf_q, rf_d;
  logic [1:0]       winner_q, winner_d;
  logic             wv_q, wv_d;

  logic             cd_load, cd_dec;
  logic             hold_load, hold_dec;
  logic             lap_clr;
  logic             in_race;
  logic [CD_W-1:0]  cd_cnt;
  logic [HOLD_W-1:0] hold_cnt;

  logic [N_PLAYERS-1:0] lap_hit;
  logic                 any_hit;
  logic [1:0]           hit_idx;

  assign in_race = (state_q == ST_RACE);

  frame_down_counter #(.W(CD_W)) u_cd_cnt (
    .clk      (pclk),
    .rst      (rst),
    .load     (cd_load),
    .load_val (CD_INIT),
    .dec      (cd_dec),
    .count    (cd_cnt)
  );

  frame_down_counter #(.W(HOLD_W)) u_hold_cnt (
    .clk      (pclk),
    .rst      (rst),
    .load     (hold_load),
    .load_val (FIN_INIT),
    .dec      (hold_dec),
    .count    (hold_cnt)
  );

  for (genvar g = 0; g < N_PLAYERS; g++) begin : g_car
    logic [LAP_W-1:0] lap_q, lap_d;

    always_comb begin
      lap_d = lap_q;
      if (lap_clr) begin
        lap_d = '0;
      end else if (in_race && lap_pulse[g] && (lap_q != LAP_MAX)) begin
        lap_d = lap_q + 1'b1;
      end
    end

    always_ff @(posedge pclk) begin
      if (rst) begin
        lap_q <= '0;
      end else begin
        lap_q <= lap_d;
      end
    end

    // A hit is the lap that moves this car from LAPS-1 to LAPS.
    assign lap_hit[g] = in_race && lap_pulse[g] && (lap_q == LAP_MAX - 1'b1);
    assign laps[g*LAP_W +: LAP_W] = lap_q;
  end

  always_comb begin
    hit_idx = '0;
    any_hit = 1'b0;
    for (int unsigned i = 0; i < N_PLAYERS; i++) begin
      if (lap_hit[i] && !any_hit) begin
        hit_idx = 2'(i);
        any_hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rf_d      = rf_q;
    winner_d  = winner_q;
    wv_d      = wv_q;
    cd_load   = 1'b0;
    cd_dec    = 1'b0;
    hold_load = 1'b0;
    hold_dec  = 1'b0;
    lap_clr   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_COUNTDOWN;
          cd_load = 1'b1;
          lap_clr = 1'b1;
          rf_d    = '0;
          wv_d    = 1'b0;
        end
      end
      ST_COUNTDOWN: begin
        if (frame_tick) begin
          cd_dec = 1'b1;
          if (cd_cnt <= CD_W'(1)) begin
            state_d = ST_RACE;
          end
        end
      end
      ST_RACE: begin
        if (frame_tick) begin
          rf_d = rf_sat_inc(rf_q);
        end
        if (any_hit) begin
          state_d   = ST_FINISH;
          winner_d  = hit_idx;
          wv_d      = 1'b1;
          hold_load = 1'b1;
        end else if (start) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (start) begin
          state_d = ST_RACE;
        end
      end
      ST_FINISH: begin
        if (start) begin
          state_d = ST_IDLE;
        end else if (frame_tick) begin
          hold_dec = 1'b1;
          if (hold_cnt <= HOLD_W'(1)) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rf_q     <= '0;
      winner_q <= '0;
      wv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rf_q     <= rf_d;
      winner_q <= winner_d;
      wv_q     <= wv_d;
    end
  end

  assign state        = state_q;
  assign cd_left      = cd_cnt;
  assign race_frames  = rf_q;
  assign winner       = winner_q;
  assign winner_valid = wv_q;

endmodule
